usb3_rx_descram_ctrl: RTL

- RX-side control stage that sits directly upstream of the 16-bit USB3 LFSR (de)scrambler. It consumes the 4-byte-aligned symbol stream coming from the 8b/10b decoder and aligner.
- It drives the LFSR's data input, enable and reset, and detects COM and SKP K-symbols.
- It merges each LFSR result byte with the raw byte: K-symbols are never scrambled.
- It registers the descrambled word, with K flags, toward the link-layer ordered-set and packet parsers.

---
 rtl/usb3_rx_descram_ctrl.sv | 117 +++++++++++
 1 files changed

// File: rtl/usb3_rx_descram_ctrl.sv
// RX control in front of the USB3 16-bit LFSR descrambler: drives the LFSR, tracks COM lock,
// merges raw K-symbols with descrambled bytes and registers the result toward the link layer.
module usb3_rx_descram_ctrl #(
    parameter logic [15:0]  SCRAM_SEED = 16'hFFFF,
    parameter int unsigned  SKP_ERR_W  = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [31:0]          rx_data,
    input  logic [3:0]           rx_datak,
    input  logic                 rx_valid,
    input  logic                 scram_disable,
    output logic [31:0]          lfsr_data_in,
    output logic                 lfsr_scram_en,
    output logic                 lfsr_scram_rst,
    output logic [15:0]          lfsr_scram_init,
    input  logic [31:0]          lfsr_data_out,
    output logic [31:0]          out_data,
    output logic [3:0]           out_datak,
    output logic                 out_valid,
    output logic                 locked,
    output logic [SKP_ERR_W-1:0] skp_err_cnt
);

    localparam int unsigned LANES  = 4;
    localparam int unsigned BYTE_W = 8;

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   w_com;
    logic                   w_skp;
    logic                   w_partial_skp;
    logic [LANES-1:0]       w_k3c;
    logic                   w_raw_all;
    logic                   w_lfsr_en;
    logic                   w_lfsr_rst;
    logic [31:0]            w_merged;
    logic [31:0]            r_out_data;
    logic [3:0]             r_out_datak;
    logic                   r_out_valid;
    logic                   r_locked;
    logic [SKP_ERR_W-1:0]   r_skp_err_cnt;

    // Ordered-set decode on the current word
    always_comb begin
        w_k3c = '0;
        for (int i = 0; i < LANES; i++) begin
            w_k3c[i] = rx_datak[i] && (rx_data[BYTE_W*i +: BYTE_W] == 8'h3C);
        end
        w_com         = rx_valid && rx_datak[0] && (rx_data[7:0] == 8'hBC);
        w_skp         = rx_valid && (rx_datak == 4'hF) && (rx_data == 32'h3C3C_3C3C);
        w_partial_skp = rx_valid && (|w_k3c) && !w_skp;
    end

    // Lock state machine and LFSR control; a COM re-seeds, so it never also advances
    always_comb begin
        w_state_nxt = r_state;
        w_lfsr_rst  = 1'b0;
        w_lfsr_en   = 1'b0;
        w_lfsr_rst  = w_com && !scram_disable;
        w_lfsr_en   = rx_valid && !scram_disable && !w_com && !w_skp && (r_state == ST_LOCKED);
        case (r_state)
            ST_UNLOCKED: if (w_com && !scram_disable) w_state_nxt = ST_LOCKED;
            ST_LOCKED:   if (scram_disable)           w_state_nxt = ST_UNLOCKED;
            default:                                  w_state_nxt = ST_UNLOCKED;
        endcase
    end

    // Per-lane merge: K-symbols, bypass, unlocked and COM words stay raw
    always_comb begin
        w_raw_all = scram_disable || (r_state == ST_UNLOCKED) || w_com;
        w_merged  = '0;
        for (int i = 0; i < LANES; i++) begin
            w_merged[BYTE_W*i +: BYTE_W] = (rx_datak[i] || w_raw_all)
                                         ? rx_data[BYTE_W*i +: BYTE_W]
                                         : lfsr_data_out[BYTE_W*i +: BYTE_W];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= ST_UNLOCKED;
            r_locked      <= 1'b0;
            r_out_data    <= '0;
            r_out_datak   <= '0;
            r_out_valid   <= 1'b0;
            r_skp_err_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_locked    <= (w_state_nxt == ST_LOCKED);
            r_out_valid <= rx_valid;
            if (rx_valid) begin
                r_out_data  <= w_merged;
                r_out_datak <= rx_datak;
            end
            if (w_partial_skp && (r_skp_err_cnt != '1)) begin
                r_skp_err_cnt <= r_skp_err_cnt + SKP_ERR_W'(1);
            end
        end
    end

    assign lfsr_data_in    = rx_data;
    assign lfsr_scram_en   = w_lfsr_en;
    assign lfsr_scram_rst  = w_lfsr_rst;
    assign lfsr_scram_init = SCRAM_SEED;
    assign out_data        = r_out_data;
    assign out_datak       = r_out_datak;
    assign out_valid       = r_out_valid;
    assign locked          = r_locked;
    assign skp_err_cnt     = r_skp_err_cnt;

endmodule
